// File: rtl/mips32_pipe_pkg.sv
// Shared types and constants for the MIPS32 five-stage pipeline control logic:
// sequencing states, the opcodes the hazard logic decodes, and the NOP encoding.
package mips32_pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } pipe_state_e;

  localparam logic [5:0]  OP_RTYPE  = 6'h00;
  localparam logic [5:0]  OP_SW     = 6'h2B;
  localparam logic [5:0]  OP_BEQ    = 6'h04;
  localparam logic [5:0]  OP_BNE    = 6'h05;
  localparam logic [5:0]  OP_HLT    = 6'h3F;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Only these formats read rt as a source; for everything else rt is a destination.
  function automatic logic op_reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: flags when the instruction in IF/ID
// reads the register that a load currently in EX is about to write.
module load_use_detect
  import mips32_pipe_pkg::*;
(
  input  logic [31:0] id_ir,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rt,
  output logic        hz
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_match;
  logic       rt_match;
  logic       unused_low_bits;

  assign op = id_ir[31:26];
  assign rs = id_ir[25:21];
  assign rt = id_ir[20:16];
  assign unused_low_bits = ^id_ir[15:0];

  assign rs_match = (ex_rt == rs);
  assign rt_match = (ex_rt == rt) && op_reads_rt(op);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hz = ex_is_load && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls (LOAD_LAT bubbles), taken-branch
// flushes and HLT halting. Optional performance counters under PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import mips32_pipe_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_ir,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_LAT - 1);

  pipe_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        halted_q;
  logic        hz;
  logic        is_hlt;

  logic pc_we_c;
  logic if_id_we_c;
  logic if_id_flush_c;
  logic id_ex_bubble_c;

  load_use_detect u_load_use_detect (
    .id_ir      (id_ir),
    .ex_is_load (ex_is_load),
    .ex_rt      (ex_rt),
    .hz         (hz)
  );

  assign is_hlt = (id_ir[31:26] == OP_HLT);

  // NOTE: every signal driven here gets a default first, so no path through the
  // case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_we_c        = 1'b1;
    if_id_we_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end else if (hz) begin
          pc_we_c        = 1'b0;
          if_id_we_c     = 1'b0;
          id_ex_bubble_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = STALL_RELOAD;
          end
        end else if (is_hlt) begin
          pc_we_c        = 1'b0;
          if_id_we_c     = 1'b0;
          id_ex_bubble_c = 1'b1;
          state_d        = HALT;
        end
      end

      STALL: begin
        if (ex_branch_taken) begin
          // A taken branch squashes the dependent instruction, so the rest of the stall is moot.
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          state_d        = RUN;
          cnt_d          = 3'd0;
        end else begin
          pc_we_c        = 1'b0;
          if_id_we_c     = 1'b0;
          id_ex_bubble_c = 1'b1;
          cnt_d          = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end
      end

      HALT: begin
        pc_we_c        = 1'b0;
        if_id_we_c     = 1'b0;
        id_ex_bubble_c = 1'b1;
      end

      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALT);
    end
  end

  // While reset is held the pipeline is frozen and filled with NOPs.
  always_comb begin
    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      pc_we        = pc_we_c;
      if_id_we     = if_id_we_c;
      if_id_flush  = if_id_flush_c;
      id_ex_bubble = id_ex_bubble_c;
    end
  end

  assign halted = halted_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (!pc_we && (state_q != HALT) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (if_id_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
